// File: rtl/hero_char_ctrl.sv
// hero_char_ctrl: player character movement with collision revert, plus bomb fuse.
// Each frame tick moves the character by the keys and gravity, waits for the
// renderer's collision output to settle, and undoes the move on a hit. The bomb
// runs on its own: drop on the f_key rising edge, two burning stages, then an
// explosion stage that ends by clearing the bomb.
module hero_char_ctrl #(
    parameter int START_X       = 125,
    parameter int START_Y       = 60,
    parameter int STEP_X        = 2,
    parameter int STEP_Y        = 2,
    parameter int GRAV          = 1,
    parameter int X_MIN         = 14,
    parameter int X_MAX         = 621,
    parameter int Y_MIN         = 29,
    parameter int Y_MAX         = 446,
    parameter int SETTLE        = 2,
    parameter int BOMB_DY       = 18,
    parameter int BOMB_TICKS    = 30,
    parameter int EXPLODE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       level_start,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       f_key,
    input  logic       coll,
    output logic [9:0] char_pos_x,
    output logic [9:0] char_pos_y,
    output logic [9:0] bomb_pos_x,
    output logic [9:0] bomb_pos_y,
    output logic [3:0] b_cnt,
    output logic       explode,
    output logic       busy
);

    // Settle counter must hold SETTLE; fuse counter must hold the longer stage length.
    localparam int SW       = $clog2(SETTLE + 2);
    localparam int FUSE_MAX = (BOMB_TICKS > EXPLODE_TICKS) ? BOMB_TICKS : EXPLODE_TICKS;
    localparam int FW       = $clog2(FUSE_MAX + 2);

    // Position arithmetic is done 11-bit signed so moves below 0 or past 1023 clamp correctly.
    localparam logic signed [10:0] STEP_X_S = 11'(STEP_X);
    localparam logic signed [10:0] STEP_Y_S = 11'(STEP_Y);
    localparam logic signed [10:0] GRAV_S   = 11'(GRAV);
    localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S  = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);

    localparam logic [9:0]    START_X_U   = 10'(START_X);
    localparam logic [9:0]    START_Y_U   = 10'(START_Y);
    localparam logic [9:0]    X_MIN_U     = 10'(X_MIN);
    localparam logic [9:0]    X_MAX_U     = 10'(X_MAX);
    localparam logic [9:0]    Y_MIN_U     = 10'(Y_MIN);
    localparam logic [9:0]    Y_MAX_U     = 10'(Y_MAX);
    localparam logic [9:0]    BOMB_DY_U   = 10'(BOMB_DY);
    localparam logic [SW-1:0] SETTLE_U    = SW'(SETTLE);
    localparam logic [FW-1:0] BOMB_T_U    = FW'(BOMB_TICKS);
    localparam logic [FW-1:0] EXPLODE_T_U = FW'(EXPLODE_TICKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [9:0]      x_reg, y_reg;
    logic [9:0]      prev_x_reg, prev_y_reg;
    logic [SW-1:0]   settle_reg;
    logic [9:0]      bomb_x_reg, bomb_y_reg;
    logic [1:0]      stage_reg;
    logic [FW-1:0]   fuse_reg;
    logic [FW-1:0]   fuse_inc;
    logic            explode_reg;
    logic            f_key_prev_reg;
    logic            f_rise;
    logic            clear;
    logic            busy_int;

    logic signed [10:0] cur_x_s, cur_y_s;
    logic signed [10:0] nx_raw, ny_raw;
    logic [9:0]         nx, ny;

    // level_start behaves exactly like reset on every register.
    assign clear    = !rst_n || level_start;
    assign f_rise   = f_key && !f_key_prev_reg;
    assign fuse_inc = fuse_reg + FW'(1);

    // Movement FSM state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Movement FSM next state; ticks arriving outside IDLE are simply not looked at.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick) state_next = MOVE;
            MOVE:    state_next = CHECK;
            CHECK:   if (settle_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Movement FSM outputs.
    always_comb begin
        busy_int = (state_reg != IDLE);
    end

    // Candidate position from keys and gravity, clamped to the playfield.
    always_comb begin
        cur_x_s = signed'({1'b0, x_reg});
        cur_y_s = signed'({1'b0, y_reg});
        nx_raw  = cur_x_s;
        if (key_left && !key_right) begin
            nx_raw = cur_x_s - STEP_X_S;
        end else if (key_right && !key_left) begin
            nx_raw = cur_x_s + STEP_X_S;
        end
        ny_raw = key_up ? (cur_y_s - STEP_Y_S) : (cur_y_s + GRAV_S);

        nx = nx_raw[9:0];
        if (nx_raw < X_MIN_S) begin
            nx = X_MIN_U;
        end else if (nx_raw > X_MAX_S) begin
            nx = X_MAX_U;
        end
        ny = ny_raw[9:0];
        if (ny_raw < Y_MIN_S) begin
            ny = Y_MIN_U;
        end else if (ny_raw > Y_MAX_S) begin
            ny = Y_MAX_U;
        end
    end

    // Character position: apply move in MOVE, revert in CHECK once coll has settled.
    always_ff @(posedge clk) begin
        if (clear) begin
            x_reg      <= START_X_U;
            y_reg      <= START_Y_U;
            prev_x_reg <= START_X_U;
            prev_y_reg <= START_Y_U;
            settle_reg <= '0;
        end else begin
            case (state_reg)
                MOVE: begin
                    prev_x_reg <= x_reg;
                    prev_y_reg <= y_reg;
                    x_reg      <= nx;
                    y_reg      <= ny;
                    settle_reg <= SETTLE_U;
                end
                CHECK: begin
                    if (settle_reg == '0) begin
                        if (coll) begin
                            x_reg <= prev_x_reg;
                            y_reg <= prev_y_reg;
                        end
                    end else begin
                        settle_reg <= settle_reg - SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bomb drop, fuse stages and explosion pulse; a drop wins over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (clear) begin
            f_key_prev_reg <= 1'b0;
            bomb_x_reg     <= '0;
            bomb_y_reg     <= '0;
            stage_reg      <= 2'd0;
            fuse_reg       <= '0;
            explode_reg    <= 1'b0;
        end else begin
            f_key_prev_reg <= f_key;
            explode_reg    <= 1'b0;
            if (f_rise && stage_reg == 2'd0) begin
                bomb_x_reg <= x_reg;
                bomb_y_reg <= y_reg + BOMB_DY_U;
                stage_reg  <= 2'd1;
                fuse_reg   <= '0;
            end else if (tick && stage_reg != 2'd0) begin
                if (stage_reg == 2'd3) begin
                    if (fuse_inc == EXPLODE_T_U) begin
                        stage_reg  <= 2'd0;
                        fuse_reg   <= '0;
                        bomb_x_reg <= '0;
                        bomb_y_reg <= '0;
                    end else begin
                        fuse_reg <= fuse_inc;
                    end
                end else if (fuse_inc == BOMB_T_U) begin
                    stage_reg <= stage_reg + 2'd1;
                    fuse_reg  <= '0;
                    if (stage_reg == 2'd2) begin
                        explode_reg <= 1'b1;
                    end
                end else begin
                    fuse_reg <= fuse_inc;
                end
            end
        end
    end

    assign char_pos_x = x_reg;
    assign char_pos_y = y_reg;
    assign bomb_pos_x = bomb_x_reg;
    assign bomb_pos_y = bomb_y_reg;
    assign b_cnt      = {2'b00, stage_reg};
    assign explode    = explode_reg;
    assign busy       = busy_int;

endmodule

// File: tb/tb_hero_char_ctrl.sv
// tb_hero_char_ctrl: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model of the character and bomb rules.
module tb_hero_char_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       level_start;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       f_key;
    logic       coll;
    logic [9:0] char_pos_x;
    logic [9:0] char_pos_y;
    logic [9:0] bomb_pos_x;
    logic [9:0] bomb_pos_y;
    logic [3:0] b_cnt;
    logic       explode;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_expl  = 0;

    // Reference model state
    int m_x, m_y, m_px, m_py;
    int m_rem;                 // clocks left until the current move is finished
    int m_bact, m_age;         // bomb active, frame ticks since drop
    int m_bx, m_by;
    int m_prevf, m_expl;

    hero_char_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .level_start(level_start),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_up     (key_up),
        .f_key      (f_key),
        .coll       (coll),
        .char_pos_x (char_pos_x),
        .char_pos_y (char_pos_y),
        .bomb_pos_x (bomb_pos_x),
        .bomb_pos_y (bomb_pos_y),
        .b_cnt      (b_cnt),
        .explode    (explode),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int model_stage();
        if (m_bact == 0) return 0;
        if (m_age < 30) return 1;
        if (m_age < 60) return 2;
        return 3;
    endfunction

    // Apply the rules for one clock edge using the inputs that were presented to it.
    task automatic model_edge();
        int ox, oy, dx;
        ox = m_x;
        oy = m_y;
        if (!rst_n || level_start) begin
            m_x = 125; m_y = 60; m_px = 125; m_py = 60; m_rem = 0;
            m_bact = 0; m_age = 0; m_bx = 0; m_by = 0; m_prevf = 0; m_expl = 0;
            return;
        end
        // movement: move lands one clock after the accepted tick, decision SETTLE+2 after
        if (m_rem == 0) begin
            if (tick) m_rem = SETTLE + 2;
        end else begin
            if (m_rem == SETTLE + 2) begin
                m_px = m_x;
                m_py = m_y;
                dx = 0;
                if (key_left && !key_right) dx = -2;
                if (key_right && !key_left) dx = 2;
                m_x = clampi(m_x + dx, 14, 621);
                m_y = clampi(m_y + (key_up ? -2 : 1), 29, 446);
            end
            if (m_rem == 1 && coll) begin
                m_x = m_px;
                m_y = m_py;
            end
            m_rem--;
        end
        // bomb
        m_expl = 0;
        if (f_key && !m_prevf && m_bact == 0) begin
            m_bact = 1; m_age = 0; m_bx = ox; m_by = oy + 18;
        end else if (m_bact != 0 && tick) begin
            m_age++;
            if (m_age == 60) m_expl = 1;
            if (m_age == 68) begin
                m_bact = 0; m_bx = 0; m_by = 0;
            end
        end
        m_prevf = f_key;
    endtask

    // One clock: edge, model update, then compare away from the edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        if (explode === 1'b1) n_expl++;
        check_eq("char_x",  32'(char_pos_x), 32'(m_x));
        check_eq("char_y",  32'(char_pos_y), 32'(m_y));
        check_eq("bomb_x",  32'(bomb_pos_x), 32'(m_bx));
        check_eq("bomb_y",  32'(bomb_pos_y), 32'(m_by));
        check_eq("b_cnt",   32'(b_cnt),      32'(model_stage()));
        check_eq("explode", 32'(explode),    32'(m_expl));
        check_eq("busy",    32'(busy),       32'(m_rem != 0));
    endtask

    task automatic step(input logic t, input logic ls, input logic kl, input logic kr,
                        input logic ku, input logic fk, input logic c);
        tick = t; level_start = ls; key_left = kl; key_right = kr;
        key_up = ku; f_key = fk; coll = c;
        cyc();
    endtask

    task automatic tick_frame(input logic kl, input logic kr, input logic ku,
                              input logic fk, input logic c);
        step(1'b1, 1'b0, kl, kr, ku, fk, c);
        repeat (4) step(1'b0, 1'b0, kl, kr, ku, fk, c);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; level_start = 1'b0; key_left = 1'b0;
        key_right = 1'b0; key_up = 1'b0; f_key = 1'b0; coll = 1'b0;
        m_x = 0; m_y = 0; m_px = 0; m_py = 0; m_rem = 0;
        m_bact = 0; m_age = 0; m_bx = 0; m_by = 0; m_prevf = 0; m_expl = 0;

        // reset held for two clocks
        cyc();
        cyc();
        check_eq("rst_x", 32'(char_pos_x), 32'd125);
        check_eq("rst_y", 32'(char_pos_y), 32'd60);
        check_eq("rst_bomb", 32'({bomb_pos_x, bomb_pos_y}), 32'd0);
        check_eq("rst_bcnt", 32'(b_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // move right with collision: visible for three clocks, then reverted
        step(1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        check_eq("rev_mv_x", 32'(char_pos_x), 32'd127);
        check_eq("rev_mv_y", 32'(char_pos_y), 32'd61);
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        check_eq("rev_hold_x", 32'(char_pos_x), 32'd127);
        step(0, 0, 0, 1, 0, 0, 1);
        check_eq("rev_back_x", 32'(char_pos_x), 32'd125);
        check_eq("rev_back_y", 32'(char_pos_y), 32'd60);
        check_eq("rev_busy", 32'(busy), 32'd0);

        // move right without collision: kept
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check_eq("mv_x", 32'(char_pos_x), 32'd127);
        check_eq("mv_y", 32'(char_pos_y), 32'd61);
        repeat (4) step(0, 0, 0, 1, 0, 0, 0);
        check_eq("mv_keep_x", 32'(char_pos_x), 32'd127);
        check_eq("mv_keep_y", 32'(char_pos_y), 32'd61);
        check_eq("mv_busy", 32'(busy), 32'd0);

        // clamp to top-left, then fall to the floor while pressing left
        repeat (70) tick_frame(1, 0, 1, 0, 0);
        check_eq("clamp_xmin", 32'(char_pos_x), 32'd14);
        check_eq("clamp_ymin", 32'(char_pos_y), 32'd29);
        repeat (420) tick_frame(1, 0, 0, 0, 0);
        check_eq("clamp_xmin2", 32'(char_pos_x), 32'd14);
        check_eq("clamp_ymax", 32'(char_pos_y), 32'd446);

        // bomb lifecycle at (14,446), second press during the fuse ignored
        step(0, 0, 0, 0, 0, 1, 0);
        check_eq("drop_bx", 32'(bomb_pos_x), 32'd14);
        check_eq("drop_by", 32'(bomb_pos_y), 32'd464);
        check_eq("drop_bcnt", 32'(b_cnt), 32'd1);
        n_expl = 0;
        for (int k = 1; k <= 68; k++) begin
            tick_frame(0, 0, 0, (k == 10 || k == 45), 0);
            if (k == 30) check_eq("fuse_30", 32'(b_cnt), 32'd2);
            if (k == 60) begin
                check_eq("fuse_60", 32'(b_cnt), 32'd3);
                check_eq("explode_once", 32'(n_expl), 32'd1);
            end
        end
        check_eq("fuse_68", 32'(b_cnt), 32'd0);
        check_eq("bomb_clr", 32'({bomb_pos_x, bomb_pos_y}), 32'd0);

        // level_start mid-CHECK with the fuse in stage 2
        step(0, 0, 0, 0, 0, 1, 0);
        repeat (35) tick_frame(0, 1, 1, 0, 0);
        check_eq("ls_pre_bcnt", 32'(b_cnt), 32'd2);
        step(1, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 1, 0, 1, 1, 0, 1);
        check_eq("ls_x", 32'(char_pos_x), 32'd125);
        check_eq("ls_y", 32'(char_pos_y), 32'd60);
        check_eq("ls_bcnt", 32'(b_cnt), 32'd0);
        check_eq("ls_busy", 32'(busy), 32'd0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        check_eq("ls_norev_x", 32'(char_pos_x), 32'd125);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            rst_n       = ($urandom_range(0, 699) != 0);
            level_start = ($urandom_range(0, 499) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                key_left  = $urandom_range(0, 1) == 1;
                key_right = $urandom_range(0, 1) == 1;
                key_up    = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 9) == 0) f_key = ~f_key;
            coll = $urandom_range(0, 1) == 1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
